// File: rtl/comparator_search_engine_if.sv
// Handshake and comparator bundle between the search engine and its environment.
// The slave modport is the engine; the master modport is the controller/comparator side.
interface comparator_search_engine_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Start_In;
    logic [DATA_WIDTH-1:0] Lower_Bound_In;
    logic [DATA_WIDTH-1:0] Upper_Bound_In;
    logic [DATA_WIDTH-1:0] Probe_Out;
    logic                  A_Less_Than_B_In;
    logic                  A_Equal_To_B_In;
    logic                  A_Greater_Than_B_In;
    logic                  Busy_Out;
    logic                  Done_Out;
    logic                  Found_Out;
    logic [DATA_WIDTH-1:0] Result_Out;
    logic [5:0]            Iterations_Out;
    logic                  Error_Out;

    modport master (
        output Start_In, Lower_Bound_In, Upper_Bound_In,
        output A_Less_Than_B_In, A_Equal_To_B_In, A_Greater_Than_B_In,
        input  Probe_Out, Busy_Out, Done_Out, Found_Out, Result_Out, Iterations_Out, Error_Out
    );

    modport slave (
        input  Start_In, Lower_Bound_In, Upper_Bound_In,
        input  A_Less_Than_B_In, A_Equal_To_B_In, A_Greater_Than_B_In,
        output Probe_Out, Busy_Out, Done_Out, Found_Out, Result_Out, Iterations_Out, Error_Out
    );
endinterface

// File: rtl/comparator_search_engine.sv
// Binary search of a hidden target through an external comparator driven by Probe_Out.
// Define COMPARATOR_FLAG_CHECK_EN to reject any comparator result that is not exactly one-hot.
module comparator_search_engine #(
    parameter int DATA_WIDTH = 32
) (
    input logic                        Clock_In,
    input logic                        Reset_N_In,
    comparator_search_engine_if.slave  bus
);
    // state  | meaning
    // IDLE   | waiting for Start_In, outputs of last search held
    // CHECK  | empty-range test, registers next probe midpoint
    // PROBE  | comparator settle cycle
    // EVAL   | sample flags, narrow lo/hi or finish
    // DONE   | one-cycle Done_Out pulse
    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PROBE, S_EVAL, S_DONE} state_t;

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] lo, hi, probe, result;
    logic [5:0]            iter;
    logic                  found, error_q;
    logic                  dec_eq, dec_lt, flag_err;
    logic [2:0]            flags;

    assign flags = {bus.A_Equal_To_B_In, bus.A_Less_Than_B_In, bus.A_Greater_Than_B_In};

    always_comb begin
        dec_eq   = 1'b0;
        dec_lt   = 1'b0;
        flag_err = 1'b0;
`ifdef COMPARATOR_FLAG_CHECK_EN
        // Case-equality so that X/Z on any flag falls through to the error path.
        if (flags === 3'b100)      dec_eq   = 1'b1;
        else if (flags === 3'b010) dec_lt   = 1'b1;
        else if (flags !== 3'b001) flag_err = 1'b1;
`else
        casez (flags)
            3'b1??:  dec_eq = 1'b1;
            3'b01?:  dec_lt = 1'b1;
            default: ;
        endcase
`endif
    end

    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) state <= S_IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.Start_In) state_nxt = S_CHECK;
            S_CHECK: state_nxt = (lo > hi) ? S_DONE : S_PROBE;
            S_PROBE: state_nxt = S_EVAL;
            S_EVAL: begin
                if (flag_err || dec_eq)  state_nxt = S_DONE;
                else if (dec_lt)         state_nxt = (probe == lo) ? S_DONE : S_CHECK;
                else                     state_nxt = (probe == hi) ? S_DONE : S_CHECK;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.Busy_Out = 1'b0;
        bus.Done_Out = 1'b0;
        case (state)
            S_CHECK, S_PROBE, S_EVAL: bus.Busy_Out = 1'b1;
            S_DONE:                   bus.Done_Out = 1'b1;
            default: ;
        endcase
    end

    // Guards on probe==lo / probe==hi keep the bounds from wrapping at 0 and all-ones.
    always_ff @(posedge Clock_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            lo      <= '0;
            hi      <= '0;
            probe   <= '0;
            result  <= '0;
            iter    <= '0;
            found   <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (bus.Start_In) begin
                    lo      <= bus.Lower_Bound_In;
                    hi      <= bus.Upper_Bound_In;
                    iter    <= '0;
                    found   <= 1'b0;
                    result  <= '0;
                    error_q <= 1'b0;
                end
                S_CHECK: if (lo <= hi) probe <= lo + ((hi - lo) >> 1);
                S_EVAL: begin
                    if (iter != 6'd63) iter <= iter + 6'd1;
                    if (flag_err) error_q <= 1'b1;
                    else if (dec_eq) begin
                        found  <= 1'b1;
                        result <= probe;
                    end else if (dec_lt) begin
                        if (probe != lo) hi <= probe - ONE;
                    end else if (probe != hi) begin
                        lo <= probe + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Probe_Out      = probe;
    assign bus.Found_Out      = found;
    assign bus.Result_Out     = result;
    assign bus.Iterations_Out = iter;
    assign bus.Error_Out      = error_q;
endmodule

// File: tb/tb_comparator_search_engine.sv
// Scoreboard bench for comparator_search_engine: driver pushes model predictions, monitor checks on Done_Out.
module tb_comparator_search_engine;
    localparam int DW = 32;

    typedef struct {
        bit          found;
        logic [31:0] result;
        int          iters;
        bit          err;
        int          lat;
        logic [31:0] last_probe;
        int          start_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] target = '0;
    logic        force_bad = 1'b0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] rl, rh, rt;
    int          n;

    comparator_search_engine_if #(.DATA_WIDTH(DW)) bus();

    comparator_search_engine #(.DATA_WIDTH(DW)) dut (
        .Clock_In   (clk),
        .Reset_N_In (rst_n),
        .bus        (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Ideal comparator: A is the hidden target, B is the probe.
    assign bus.A_Less_Than_B_In    = force_bad ? 1'b1 : (target <  bus.Probe_Out);
    assign bus.A_Equal_To_B_In     = force_bad ? 1'b0 : (target == bus.Probe_Out);
    assign bus.A_Greater_Than_B_In = force_bad ? 1'b1 : (target >  bus.Probe_Out);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: textbook inclusive binary search on 64-bit integers, counting comparator
    // evaluations and the cycle at which the search would end (CHECK+PROBE+EVAL per probe).
    function automatic exp_t model(input logic [31:0] lo_i, input logic [31:0] hi_i,
                                   input logic [31:0] tgt_i, input bit force_less);
        exp_t   e;
        longint lo, hi, tgt, p;
        int     t;
        e = '{default: 0};
        lo = longint'({32'b0, lo_i});
        hi = longint'({32'b0, hi_i});
        tgt = longint'({32'b0, tgt_i});
        t = 1;
        while (1) begin
            if (lo > hi) begin
                e.lat = t + 1;
                return e;
            end
            p = lo + (hi - lo) / 2;
            e.last_probe = p[31:0];
            e.iters++;
            if (force_less && e.iters == 1) begin
`ifdef COMPARATOR_FLAG_CHECK_EN
                e.err = 1'b1;
                e.lat = t + 3;
                return e;
`else
                if (p == lo) begin
                    e.lat = t + 3;
                    return e;
                end
                hi = p - 1;
`endif
            end else if (tgt == p) begin
                e.found = 1'b1;
                e.result = p[31:0];
                e.lat = t + 3;
                return e;
            end else if (tgt < p) begin
                if (p == lo) begin
                    e.lat = t + 3;
                    return e;
                end
                hi = p - 1;
            end else begin
                if (p == hi) begin
                    e.lat = t + 3;
                    return e;
                end
                lo = p + 1;
            end
            t += 3;
        end
        return e;
    endfunction

    task automatic wait_idle(output bit ok);
        int k;
        k = 0;
        while ((bus.Busy_Out !== 1'b0 || bus.Done_Out !== 1'b0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        ok = (k < 300);
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL idle_wait: engine still busy after %0d cycles, expected idle", k);
        end
    endtask

    task automatic run(input logic [31:0] lo, input logic [31:0] hi,
                       input logic [31:0] tgt, input bit bad);
        exp_t e;
        bit   ok;
        wait_idle(ok);
        if (!ok) return;
        target = tgt;
        bus.Lower_Bound_In = lo;
        bus.Upper_Bound_In = hi;
        bus.Start_In = 1'b1;
        force_bad = bad;
        e = model(lo, hi, tgt, bad);
        e.start_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.Start_In = 1'b0;
        if (bad) begin
            repeat (3) @(negedge clk);
            force_bad = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.Done_Out === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got Done_Out=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("found",      bus.Found_Out,      mon_e.found);
                check("result",     bus.Result_Out,     mon_e.result);
                check("iterations", bus.Iterations_Out, mon_e.iters[5:0]);
                check("error",      bus.Error_Out,      mon_e.err);
                check("latency",    cyc - mon_e.start_cyc, mon_e.lat);
                check("busy_at_done", bus.Busy_Out,     1'b0);
                if (mon_e.iters > 0) check("probe_held", bus.Probe_Out, mon_e.last_probe);
            end
        end
    end

    initial begin
        bus.Start_In = 1'b0;
        bus.Lower_Bound_In = '0;
        bus.Upper_Bound_In = '0;
        repeat (2) @(negedge clk);
        check("rst_busy",  bus.Busy_Out,       1'b0);
        check("rst_done",  bus.Done_Out,       1'b0);
        check("rst_found", bus.Found_Out,      1'b0);
        check("rst_result", bus.Result_Out,    32'h0);
        check("rst_iters", bus.Iterations_Out, 6'h0);
        check("rst_error", bus.Error_Out,      1'b0);
        check("rst_probe", bus.Probe_Out,      32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run(32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        run(32'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run(32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run(32'd100, 32'd200, 32'd50, 1'b0);
        run(32'd10, 32'd5, 32'd7, 1'b0);
        run(32'd7, 32'd7, 32'd7, 1'b0);
        run(32'd100, 32'd200, 32'd250, 1'b0);

        run(32'd0, 32'd1000, 32'd100, 1'b1);
        @(negedge clk);
`ifndef COMPARATOR_FLAG_CHECK_EN
        check("probe_after_forced_less", bus.Probe_Out, 32'd249);
`endif

        // Abort during the third probe: everything clears at once, no Done pulse.
        begin
            bit ok;
            wait_idle(ok);
            target = 32'h1234_5678;
            bus.Lower_Bound_In = 32'h0;
            bus.Upper_Bound_In = 32'hFFFF_FFFF;
            bus.Start_In = 1'b1;
            @(negedge clk);
            bus.Start_In = 1'b0;
            repeat (7) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("abort_busy",  bus.Busy_Out,       1'b0);
            check("abort_done",  bus.Done_Out,       1'b0);
            check("abort_found", bus.Found_Out,      1'b0);
            check("abort_result", bus.Result_Out,    32'h0);
            check("abort_iters", bus.Iterations_Out, 6'h0);
            check("abort_error", bus.Error_Out,      1'b0);
            check("abort_probe", bus.Probe_Out,      32'h0);
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
        end
        run(32'h0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rl = $urandom;
            if (i % 4 == 0) rh = $urandom;
            else rh = (rl > 32'hFFFF_F000) ? 32'hFFFF_FFFF : rl + $urandom_range(0, 4000);
            case ($urandom_range(0, 5))
                0:       rt = $urandom;
                1:       rt = rl;
                2:       rt = rh;
                default: rt = (rh >= rl) ? rl + $urandom_range(0, rh - rl) : $urandom;
            endcase
            run(rl, rh, rt, 1'b0);
        end

        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d searches outstanding, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
